// File: rtl/atm_pkg.sv
// Shared types and default configuration for the ATM session controller.
// DEF_WD_LIMIT exists only when ATM_WD_LIMIT_EN is defined.
package atm_pkg;

   localparam int DEF_USERS_NUM    = 7;
   localparam int DEF_PSW_W        = 4;
   localparam int DEF_BAL_W        = 20;
   localparam int DEF_CARD_W       = 3;
   localparam int DEF_MAX_TRIES    = 3;
   localparam int DEF_TIMEOUT_CYC  = 15;
   localparam int DEF_INIT_BALANCE = 1000;
`ifdef ATM_WD_LIMIT_EN
   localparam int DEF_WD_LIMIT     = 5000;
`endif

   // Read-only PIN image, card 0 in the least significant nibble.
   localparam logic [DEF_USERS_NUM*DEF_PSW_W-1:0] DEF_PSW_IMAGE =
      {4'd1, 4'd12, 4'd7, 4'd2, 4'd13, 4'd8, 4'd3};

   typedef enum logic [1:0] {
      OP_WD   = 2'b00,
      OP_DEP  = 2'b01,
      OP_INQ  = 2'b10,
      OP_XFER = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LANG,
      ST_PSW,
      ST_OP_SEL,
      ST_EXEC,
      ST_MORE,
      ST_EJECT
   } state_t;

endpackage

// File: rtl/atm_timeout_cnt.sv
// Idle-cycle counter: expired_o rises on the TIMEOUT_CYC-th consecutive enabled cycle.
module atm_timeout_cnt #(
   parameter int TIMEOUT_CYC = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && !expired_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card/PIN check with lockout, withdraw/deposit/inquiry/transfer on a balance store.
// Define ATM_WD_LIMIT_EN to cap the per-session withdraw+transfer total at WD_LIMIT.
module atm_session_ctrl
   import atm_pkg::*;
#(
   parameter int USERS_NUM    = DEF_USERS_NUM,
   parameter int PSW_W        = DEF_PSW_W,
   parameter int BAL_W        = DEF_BAL_W,
   parameter int CARD_W       = DEF_CARD_W,
   parameter int MAX_TRIES    = DEF_MAX_TRIES,
   parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
   parameter int INIT_BALANCE = DEF_INIT_BALANCE,
   parameter logic [USERS_NUM*PSW_W-1:0] PSW_IMAGE = DEF_PSW_IMAGE
`ifdef ATM_WD_LIMIT_EN
   , parameter int WD_LIMIT   = DEF_WD_LIMIT
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              card_in,
   input  logic [CARD_W-1:0] card_number,
   input  logic [PSW_W-1:0]  password_input,
   input  logic              language,
   input  logic              op_valid,
   input  logic [1:0]        operation,
   input  logic [BAL_W-1:0]  value,
   input  logic [CARD_W-1:0] dest_card,
   input  logic              another_service,
   output logic              card_out,
   output logic              lang_sel,
   output logic [BAL_W-1:0]  updated_balance,
   output logic              op_done,
   output logic              error,
   output logic              wrong_psw,
   output logic              card_locked
);

   localparam int TRY_W  = $clog2(MAX_TRIES + 1);
   localparam int LOCK_N = 2 ** CARD_W;

   state_t            state_q, state_d;
   logic [CARD_W-1:0] src_q, src_d, dst_q, dst_d;
   op_t               op_q, op_d;
   logic [BAL_W-1:0]  val_q, val_d;
   logic [TRY_W-1:0]  tries_q, tries_d;
   logic [LOCK_N-1:0] lock_q, lock_d;
   logic              card_out_q, card_out_d, lang_q, lang_d;
   logic              op_done_q, op_done_d, err_q, err_d, wrong_q, wrong_d;
   logic [BAL_W-1:0]  upd_q, upd_d;
   logic [BAL_W-1:0]  bal_q [USERS_NUM];

   logic              card_ok, pin_ok, expired;
   logic [BAL_W-1:0]  src_bal, dst_bal, src_new, dst_new;
   logic [BAL_W:0]    dep_sum, xfer_sum;
   logic              dst_ok, fund_ok, limit_ok, exec_ok, src_we, dst_we;
   logic [USERS_NUM-1:0] acct_we;
   logic [BAL_W-1:0]  acct_wd [USERS_NUM];

   // Lock vector spans every encodable card so out-of-range numbers read as unlocked.
   assign card_ok  = (32'(card_number) < USERS_NUM) && !lock_q[card_number];
   assign pin_ok   = (password_input == PSW_IMAGE[int'(src_q)*PSW_W +: PSW_W]);
   assign src_bal  = bal_q[src_q];
   assign dst_bal  = bal_q[dst_q];
   assign dst_ok   = (32'(dst_q) < USERS_NUM) && (dst_q != src_q);
   assign fund_ok  = (val_q <= src_bal);
   assign dep_sum  = {1'b0, src_bal} + {1'b0, val_q};
   assign xfer_sum = {1'b0, dst_bal} + {1'b0, val_q};

`ifdef ATM_WD_LIMIT_EN
   logic [BAL_W:0]   total_q, total_d;
   logic [BAL_W+1:0] total_sum;
   assign total_sum = {1'b0, total_q} + {2'b00, val_q};
   assign limit_ok  = (total_sum <= (BAL_W+2)'(WD_LIMIT));
`else
   assign limit_ok  = 1'b1;
`endif

   always_comb begin
      exec_ok = 1'b0;
      src_new = src_bal;
      dst_new = dst_bal;
      case (op_q)
         OP_WD: begin
            exec_ok = fund_ok && limit_ok;
            src_new = src_bal - val_q;
         end
         OP_DEP: begin
            exec_ok = !dep_sum[BAL_W];
            src_new = dep_sum[BAL_W-1:0];
         end
         OP_INQ: exec_ok = 1'b1;
         OP_XFER: begin
            exec_ok = dst_ok && fund_ok && !xfer_sum[BAL_W] && limit_ok;
            src_new = src_bal - val_q;
            dst_new = xfer_sum[BAL_W-1:0];
         end
         default: exec_ok = 1'b0;
      endcase
   end

   assign src_we = (state_q == ST_EXEC) && exec_ok && (op_q != OP_INQ);
   assign dst_we = src_we && (op_q == OP_XFER);

   // A transfer writes source and destination in the same cycle; they never alias.
   genvar gi;
   for (gi = 0; gi < USERS_NUM; gi++) begin : g_acct
      logic hit_src, hit_dst;
      assign hit_src     = src_we && (src_q == CARD_W'(gi));
      assign hit_dst     = dst_we && (dst_q == CARD_W'(gi));
      assign acct_we[gi] = hit_src || hit_dst;
      assign acct_wd[gi] = hit_src ? src_new : dst_new;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < USERS_NUM; i++) bal_q[i] <= BAL_W'(INIT_BALANCE);
      end else begin
         for (int i = 0; i < USERS_NUM; i++) begin
            if (acct_we[i]) bal_q[i] <= acct_wd[i];
         end
      end
   end

   atm_timeout_cnt #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (state_d != state_q),
      .enable_i  ((state_q == ST_PSW) || (state_q == ST_OP_SEL)),
      .expired_o (expired)
   );

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      op_d       = op_q;
      val_d      = val_q;
      tries_d    = tries_q;
      lock_d     = lock_q;
      card_out_d = card_out_q;
      lang_d     = lang_q;
      upd_d      = upd_q;
      op_done_d  = 1'b0;
      err_d      = 1'b0;
      wrong_d    = 1'b0;
`ifdef ATM_WD_LIMIT_EN
      total_d    = total_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (card_in) begin
               if (card_ok) begin
                  src_d      = card_number;
                  card_out_d = 1'b0;
                  state_d    = ST_LANG;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_LANG: begin
            lang_d  = language;
            state_d = ST_PSW;
         end
         ST_PSW: begin
            if (pin_ok) begin
               tries_d = '0;
               state_d = ST_OP_SEL;
            end else begin
               wrong_d = 1'b1;
               tries_d = tries_q + TRY_W'(1);
               if (tries_d == TRY_W'(MAX_TRIES)) begin
                  lock_d[src_q] = 1'b1;
                  err_d         = 1'b1;
                  state_d       = ST_EJECT;
               end else if (expired) begin
                  err_d   = 1'b1;
                  state_d = ST_EJECT;
               end
            end
         end
         ST_OP_SEL: begin
            if (op_valid) begin
               op_d    = op_t'(operation);
               val_d   = value;
               dst_d   = dest_card;
               state_d = ST_EXEC;
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = ST_EJECT;
            end
         end
         ST_EXEC: begin
            upd_d     = exec_ok ? src_new : src_bal;
            op_done_d = exec_ok;
            err_d     = !exec_ok;
`ifdef ATM_WD_LIMIT_EN
            if (exec_ok && ((op_q == OP_WD) || (op_q == OP_XFER))) total_d = total_sum[BAL_W:0];
`endif
            state_d   = ST_MORE;
         end
         ST_MORE: state_d = another_service ? ST_OP_SEL : ST_EJECT;
         ST_EJECT: begin
            card_out_d = 1'b1;
            tries_d    = '0;
`ifdef ATM_WD_LIMIT_EN
            total_d    = '0;
`endif
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         op_q       <= OP_WD;
         val_q      <= '0;
         tries_q    <= '0;
         lock_q     <= '0;
         card_out_q <= 1'b1;
         lang_q     <= 1'b0;
         upd_q      <= '0;
         op_done_q  <= 1'b0;
         err_q      <= 1'b0;
         wrong_q    <= 1'b0;
`ifdef ATM_WD_LIMIT_EN
         total_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         op_q       <= op_d;
         val_q      <= val_d;
         tries_q    <= tries_d;
         lock_q     <= lock_d;
         card_out_q <= card_out_d;
         lang_q     <= lang_d;
         upd_q      <= upd_d;
         op_done_q  <= op_done_d;
         err_q      <= err_d;
         wrong_q    <= wrong_d;
`ifdef ATM_WD_LIMIT_EN
         total_q    <= total_d;
`endif
      end
   end

   assign card_out        = card_out_q;
   assign lang_sel        = lang_q;
   assign updated_balance = upd_q;
   assign op_done         = op_done_q;
   assign error           = err_q;
   assign wrong_psw       = wrong_q;
   assign card_locked     = lock_q[card_number];

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Self-checking bench for atm_session_ctrl: directed scenarios plus random sessions against a behavioural model.
module tb_atm_session_ctrl;

   localparam int USERS = 7;
   localparam int BW    = 20;
   localparam int CW    = 3;
   localparam int PW    = 4;
   localparam int MAXT  = 3;
   localparam int TO    = 15;
   localparam longint MAXB = (longint'(1) << BW) - 1;
   localparam logic [USERS*PW-1:0] IMG = {4'd1, 4'd12, 4'd7, 4'd2, 4'd13, 4'd8, 4'd3};
`ifdef ATM_WD_LIMIT_EN
   localparam longint WDLIM = 5000;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic card_in = 1'b0, language = 1'b0, op_valid = 1'b0, another_service = 1'b0;
   logic [CW-1:0] card_number = '0, dest_card = '0;
   logic [PW-1:0] password_input = '0;
   logic [1:0]    operation = '0;
   logic [BW-1:0] value = '0;
   logic card_out, lang_sel, op_done, error, wrong_psw, card_locked;
   logic [BW-1:0] updated_balance;

   always #5 clk = ~clk;

   atm_session_ctrl #(
      .USERS_NUM(USERS), .PSW_W(PW), .BAL_W(BW), .CARD_W(CW), .MAX_TRIES(MAXT),
      .TIMEOUT_CYC(TO), .INIT_BALANCE(1000), .PSW_IMAGE(IMG)
   ) dut (
      .clk(clk), .rst(rst), .card_in(card_in), .card_number(card_number),
      .password_input(password_input), .language(language), .op_valid(op_valid),
      .operation(operation), .value(value), .dest_card(dest_card),
      .another_service(another_service), .card_out(card_out), .lang_sel(lang_sel),
      .updated_balance(updated_balance), .op_done(op_done), .error(error),
      .wrong_psw(wrong_psw), .card_locked(card_locked)
   );

   // Model state
   longint m_bal [USERS];
   bit     lock_nx [8];
   bit     lock_cur [8];
   int     tries, src;
`ifdef ATM_WD_LIMIT_EN
   longint total;
`endif

   // Expected outputs after the next rising edge, and their pipelined copies
   logic e_card_out = 1'b1, e_lang = 1'b0, e_op_done = 1'b0, e_error = 1'b0, e_wrong = 1'b0;
   logic [BW-1:0] e_bal = '0;
   logic chk_en = 1'b0;
   logic c_card_out, c_lang, c_op_done, c_error, c_wrong;
   logic [BW-1:0] c_bal;
   logic c_en = 1'b0;

   int tests = 0, fails = 0;
   int cyc = 0, n_done = 0, n_err = 0, n_wrong = 0;
   logic [BW-1:0] last_bal;
   logic last_done, last_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      c_card_out <= e_card_out;
      c_lang     <= e_lang;
      c_bal      <= e_bal;
      c_op_done  <= e_op_done;
      c_error    <= e_error;
      c_wrong    <= e_wrong;
      c_en       <= chk_en;
      lock_cur   <= lock_nx;
   end

   always @(negedge clk) begin
      if (c_en) begin
         check("card_out", 32'(card_out), 32'(c_card_out));
         check("lang_sel", 32'(lang_sel), 32'(c_lang));
         check("updated_balance", 32'(updated_balance), 32'(c_bal));
         check("op_done", 32'(op_done), 32'(c_op_done));
         check("error", 32'(error), 32'(c_error));
         check("wrong_psw", 32'(wrong_psw), 32'(c_wrong));
         check("card_locked", 32'(card_locked), 32'(lock_cur[card_number]));
      end
   end

   function automatic logic [3:0] pin_of(input int c);
      case (c)
         0: return 4'd3;
         1: return 4'd8;
         2: return 4'd13;
         3: return 4'd2;
         4: return 4'd7;
         5: return 4'd12;
         6: return 4'd1;
         default: return 4'd0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      n_done  += int'(op_done === 1'b1);
      n_err   += int'(error === 1'b1);
      n_wrong += int'(wrong_psw === 1'b1);
      e_op_done = 1'b0;
      e_error   = 1'b0;
      e_wrong   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; card_in = 1'b0; op_valid = 1'b0;
      e_card_out = 1'b1; e_lang = 1'b0; e_bal = '0;
      for (int i = 0; i < USERS; i++) m_bal[i] = 1000;
      for (int i = 0; i < 8; i++) lock_nx[i] = 1'b0;
      tries = 0;
`ifdef ATM_WD_LIMIT_EN
      total = 0;
`endif
      tick();
      rst = 1'b0;
   endtask

   task automatic eject();
      e_card_out = 1'b1;
      tries = 0;
`ifdef ATM_WD_LIMIT_EN
      total = 0;
`endif
      tick();
   endtask

   task automatic insert(input int card, input logic lang, output bit ok);
      card_in = 1'b1;
      card_number = CW'(card);
      if (card >= USERS || lock_nx[card]) begin
         e_error = 1'b1;
         tick();
         card_in = 1'b0;
         ok = 1'b0;
      end else begin
         src = card;
         e_card_out = 1'b0;
         tick();
         card_in = 1'b0;
         language = lang;
         e_lang = lang;
         tick();
         ok = 1'b1;
      end
   endtask

   task automatic enter_pin(input logic [3:0] pin, output bit ended);
      password_input = pin;
      ended = 1'b0;
      if (pin == pin_of(src)) begin
         tries = 0;
         tick();
      end else begin
         e_wrong = 1'b1;
         tries++;
         if (tries == MAXT) begin
            lock_nx[src] = 1'b1;
            e_error = 1'b1;
            tick();
            eject();
            ended = 1'b1;
         end else begin
            tick();
         end
      end
   endtask

   task automatic do_op(input int op, input int val, input int dest, input bit more);
      longint sb, nb;
      bit ok, lim;
      operation = 2'(op); value = BW'(val); dest_card = CW'(dest); op_valid = 1'b1;
      tick();
      op_valid = 1'b0;
      sb = m_bal[src];
      nb = sb;
      ok = 1'b0;
`ifdef ATM_WD_LIMIT_EN
      lim = (total + val) <= WDLIM;
`else
      lim = 1'b1;
`endif
      case (op)
         0: if (val <= sb && lim) begin ok = 1'b1; nb = sb - val; end
         1: if (sb + val <= MAXB) begin ok = 1'b1; nb = sb + val; end
         2: ok = 1'b1;
         default: if (dest < USERS && dest != src && val <= sb && lim &&
                      m_bal[dest < USERS ? dest : 0] + val <= MAXB) begin
            ok = 1'b1; nb = sb - val; m_bal[dest] = m_bal[dest] + val;
         end
      endcase
      m_bal[src] = nb;
`ifdef ATM_WD_LIMIT_EN
      if (ok && (op == 0 || op == 3)) total += val;
`endif
      e_bal = BW'(nb);
      e_op_done = ok;
      e_error = !ok;
      tick();
      last_bal = updated_balance; last_done = op_done; last_err = error;
      another_service = more;
      tick();
      if (!more) eject();
   endtask

   task automatic timeout_wait();
      op_valid = 1'b0;
      for (int i = 0; i < TO - 1; i++) tick();
      e_error = 1'b1;
      tick();
      eject();
   endtask

   function automatic int pick_value(input int dest);
      longint sb = m_bal[src];
      longint v;
      case ($urandom_range(0, 6))
         0: v = $urandom_range(0, 1500);
         1: v = sb;
         2: v = sb + 1;
         3: v = MAXB - sb;
         4: v = MAXB - sb + 1;
         5: v = $urandom & 32'(MAXB);
         default: v = (dest < USERS) ? MAXB - m_bal[dest] + 1 : 50;
      endcase
      if (v > MAXB) v = MAXB;
      return int'(v);
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
      $fatal(1);
   end

   initial begin
      bit ok, ended;
      int c0, e0, w0, card, r, nwrong, nops, op, dest, val;

      chk_en = 1'b1;
      do_reset();
      check("rst_card_out", 32'(card_out), 1);
      check("rst_balance", 32'(updated_balance), 0);

      // Withdraw 100 from card 0, eject
      c0 = cyc;
      insert(0, 1'b1, ok);
      enter_pin(4'b0011, ended);
      do_op(0, 100, 0, 1'b0);
      check("wd100_balance", 32'(last_bal), 900);
      check("wd100_done", 32'(last_done), 1);
      check("wd100_card_out", 32'(card_out), 1);
      check("wd100_cycles", 32'(cyc - c0), 7);

      // Three wrong PINs lock card 0
      e0 = n_err; w0 = n_wrong;
      insert(0, 1'b0, ok);
      for (int i = 0; i < 3; i++) enter_pin(4'b0000, ended);
      check("lock_wrong_pulses", 32'(n_wrong - w0), 3);
      check("lock_error_pulses", 32'(n_err - e0), 1);
      check("lock_card_out", 32'(card_out), 1);
      insert(0, 1'b0, ok);
      check("locked_reinsert_err", 32'(error), 1);
      check("locked_flag", 32'(card_locked), 1);

      // Transfer 300 from 1 to 2, inquiry on 2, transfer to invalid card 7
      insert(1, 1'b0, ok); enter_pin(4'd8, ended);
      do_op(3, 300, 2, 1'b0);
      check("xfer_src_balance", 32'(last_bal), 700);
      insert(2, 1'b1, ok); enter_pin(4'd13, ended);
      do_op(2, 0, 0, 1'b0);
      check("xfer_dst_balance", 32'(last_bal), 1300);
      insert(1, 1'b0, ok); enter_pin(4'd8, ended);
      do_op(3, 50, 7, 1'b1);
      check("xfer_bad_dest_err", 32'(last_err), 1);
      check("xfer_bad_dest_bal", 32'(last_bal), 700);
      do_op(2, 0, 0, 1'b0);

      // Boundaries on card 3
      insert(3, 1'b0, ok); enter_pin(4'd2, ended);
      do_op(0, 1001, 0, 1'b1);
      check("wd1001_err", 32'(last_err), 1);
      check("wd1001_bal", 32'(last_bal), 1000);
      do_op(1, (1 << 20) - 1000, 0, 1'b1);
      check("dep_overflow_err", 32'(last_err), 1);
      do_op(0, 1000, 0, 1'b0);
      check("wd_all_bal", 32'(last_bal), 0);
      check("wd_all_done", 32'(last_done), 1);

      // Timeout in OP_SEL
      e0 = n_err;
      insert(4, 1'b0, ok); enter_pin(4'd7, ended);
      timeout_wait();
      check("timeout_err", 32'(n_err - e0), 1);
      check("timeout_card_out", 32'(card_out), 1);

      // Reset while in EXEC: no write, all balances restored
      insert(5, 1'b0, ok); enter_pin(4'd12, ended);
      operation = 2'd0; value = BW'(500); op_valid = 1'b1;
      tick();
      op_valid = 1'b0;
      do_reset();
      insert(5, 1'b0, ok); enter_pin(4'd12, ended);
      do_op(2, 0, 0, 1'b0);
      check("rst_exec_bal", 32'(last_bal), 1000);
      insert(0, 1'b0, ok);
      check("rst_unlock", 32'(ok), 1);
      enter_pin(4'd3, ended);
      do_op(2, 0, 0, 1'b0);
      check("rst_card0_bal", 32'(last_bal), 1000);

      // Random sessions
      for (int s = 0; s < 80; s++) begin
         if (s % 20 == 19) do_reset();
         card = $urandom_range(0, 7);
         insert(card, 1'($urandom_range(0, 1)), ok);
         if (!ok) continue;
         r = $urandom_range(0, 9);
         nwrong = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
         ended = 1'b0;
         for (int w = 0; w < nwrong; w++) begin
            if (!ended) enter_pin(pin_of(src) ^ 4'($urandom_range(1, 15)), ended);
         end
         if (ended) continue;
         enter_pin(pin_of(src), ended);
         nops = $urandom_range(1, 4);
         for (int i = 0; i < nops; i++) begin
            if ($urandom_range(0, 19) == 0) begin
               timeout_wait();
               break;
            end
            op   = $urandom_range(0, 3);
            dest = $urandom_range(0, 7);
            val  = pick_value(dest);
            do_op(op, val, dest, i < nops - 1);
         end
      end

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
